serial_add_seq: RTL and testbench

Bit-serial adder controller: accepts two WIDTH-bit operands on a start pulse and adds them one bit per clock using a single 1-bit full-adder cell built from two half adders. It sequences the operand shifting and carry feedback, and presents the registered sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to a WIDTH-bit ripple adder in the combinational-circuits library.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/fa_cell.sv | 15 +
 rtl/halfadder.sv | 10 +
 rtl/serial_add_seq.sv | 102 ++++++++++
 tb/tb_serial_add_seq.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: controller states and counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must be at least one bit wide, even for a 1-bit adder.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder from two half adders and an OR; combinational, zero latency.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic w_s0, w_c0, w_c1;

  halfadder u_ha0 (.a(a),    .b(b),   .s(w_s0), .c(w_c0));
  halfadder u_ha1 (.a(w_s0), .b(cin), .s(s),    .c(w_c1));

  assign cout = w_c0 | w_c1;
endmodule

// File: rtl/halfadder.sv
// Half adder: s = a ^ b, c = a & b. Pure combinational, no state, no stall.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one fa_cell reused over WIDTH cycles, start->done latency WIDTH+1.
// No backpressure: start is sampled only in IDLE and ignored while busy or done.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  import serial_add_pkg::*;

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb, r_acc, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_busy, r_done;

  logic             w_s, w_c;
  logic [WIDTH-1:0] w_acc_next;

  fa_cell u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at position 0.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign w_acc_next = w_s;
    end else begin : g_acc_wn
      assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_acc   <= w_acc_next;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          // Results are published only on the final bit, never partially.
          if (r_cnt == LAST) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq at WIDTH=8 and WIDTH=1.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, busy1, done1, cout1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] prev_s [2];
  logic       prev_c [2];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [7:0] x, input logic [7:0] y);
    if (sel) begin
      start1 = s; a1 = x[0]; b1 = y[0];
    end else begin
      start8 = s; a8 = x; b8 = y;
    end
  endtask

  task automatic sample(input bit sel, output logic bz, output logic dn,
                        output logic [7:0] s, output logic c);
    if (sel) begin
      bz = busy1; dn = done1; s = {7'b0, sum1}; c = cout1;
    end else begin
      bz = busy8; dn = done8; s = sum8; c = cout8;
    end
  endtask

  // One full operation; spam keeps start high with changing operands through RUN and DONE.
  task automatic run_op(input bit sel, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [7:0] exp_s, input logic exp_c, input bit spam,
                        input string tag);
    int lat, nbusy, overlap, early, w;
    logic bz, dn, c;
    logic [7:0] s;
    w = sel ? 1 : 8;
    lat = 0; nbusy = 0; overlap = 0; early = 0;
    @(negedge clk);
    drive(sel, 1'b1, opa, opb);
    @(posedge clk);
    #1;
    drive(sel, spam, ~opa, opb + 8'd1);
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      sample(sel, bz, dn, s, c);
      if (bz) nbusy++;
      if (bz && dn) overlap++;
      if (dn) lat = k;
      else if (s !== prev_s[sel] || c !== prev_c[sel]) early++;
      if (spam) drive(sel, 1'b1, opa ^ 8'(k * 37), opb + 8'(k));
    end
    if (spam) begin
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 8'd0, 8'd0);
    end
    chk({tag, " latency"}, lat, w + 1);
    chk({tag, " busy_cycles"}, nbusy, w);
    chk({tag, " busy_done_overlap"}, overlap, 0);
    chk({tag, " early_update"}, early, 0);
    chk({tag, " sum"}, s, exp_s);
    chk({tag, " cout"}, c, exp_c);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sample(sel, bz, dn, s, c);
      chk({tag, " idle_after"}, {bz, dn}, 0);
      chk({tag, " sum_held"}, s, exp_s);
    end
    prev_s[sel] = exp_s;
    prev_c[sel] = exp_c;
  endtask

  initial begin
    int ndone;
    vecs[0] = '{a: 8'd3,   b: 8'd5,   s: 8'd8,   c: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   s: 8'd0,   c: 1'b1};
    vecs[2] = '{a: 8'd170, b: 8'd85,  s: 8'd255, c: 1'b0};
    vecs[3] = '{a: 8'd0,   b: 8'd0,   s: 8'd0,   c: 1'b0};
    vecs[4] = '{a: 8'd128, b: 8'd128, s: 8'd0,   c: 1'b1};
    vecs[5] = '{a: 8'd15,  b: 8'd240, s: 8'd255, c: 1'b0};
    vecs[6] = '{a: 8'd99,  b: 8'd27,  s: 8'd126, c: 1'b0};
    vecs[7] = '{a: 8'd255, b: 8'd255, s: 8'd254, c: 1'b1};
    prev_s[0] = 8'd0; prev_c[0] = 1'b0;
    prev_s[1] = 8'd0; prev_c[1] = 1'b0;

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset w8 busy/done/cout", {busy8, done8, cout8}, 0);
    chk("reset w8 sum", sum8, 0);
    chk("reset w1 busy/done/sum/cout", {busy1, done1, sum1, cout1}, 0);

    foreach (vecs[i]) run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'b0, $sformatf("vec%0d", i));

    run_op(1'b0, 8'd100, 8'd50, 8'd150, 1'b0, 1'b1, "spam_start");
    run_op(1'b0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, "after_spam");

    // Reset during the 4th RUN cycle of 200+100: no done, outputs cleared.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd200, 8'd100);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst busy", busy8, 0);
    chk("midrun_rst sum", sum8, 0);
    chk("midrun_rst cout", cout8, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("midrun_rst no_done", ndone, 0);
    prev_s[0] = 8'd0; prev_c[0] = 1'b0;
    prev_s[1] = 8'd0; prev_c[1] = 1'b0;
    run_op(1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, "post_rst");

    // rst and start together in IDLE: reset wins.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'd3, 8'd3);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("rst_start busy_or_done", ndone, 0);
    chk("rst_start sum", sum8, 0);
    prev_s[0] = 8'd0; prev_c[0] = 1'b0;

    run_op(1'b1, 8'd1, 8'd1, 8'd0, 1'b1, 1'b0, "w1 1+1");
    run_op(1'b1, 8'd1, 8'd0, 8'd1, 1'b0, 1'b0, "w1 1+0");
    run_op(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, "w1 0+0 spam");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
